// File: rtl/lfsr_share_arb.sv
// Round-robin arbiter sharing one LFSR among NumReq requesters: each transfer
// steps the LFSR once and hands the fresh value to exactly one requester.
module lfsr_share_arb #(
   parameter int NumReq = 4,
   parameter int Width  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NumReq-1:0] req_i,
   input  logic [NumReq-1:0] ready_i,
   output logic [NumReq-1:0] gnt_o,
   output logic              valid_o,
   output logic [Width-1:0]  data_o,
   output logic              lfsr_next_o,
   input  logic [Width-1:0]  lfsr_rand_i,
   output logic              busy_o,
   output logic [31:0]       count_o
);

   localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STEP    = 2'd1,
      DELIVER = 2'd2
   } state_e;

   state_e            state_r;
   logic [PtrW-1:0]   ptr_r;
   logic [PtrW-1:0]   g_r;
   logic [31:0]       count_r;
   logic [NumReq-1:0] gnt_r;
   logic              valid_r;
   logic              next_r;
   logic              busy_r;

   logic              sel_found_s;
   logic [PtrW-1:0]   sel_idx_s;

   function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      return (sum >= NumReq) ? PtrW'(sum - NumReq) : PtrW'(sum);
   endfunction

   function automatic logic [NumReq-1:0] onehot(input logic [PtrW-1:0] idx);
      logic [NumReq-1:0] v;
      v      = {NumReq{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // Rotating-priority pick: first requester at or after ptr, wrapping.
   always_comb begin
      sel_found_s = 1'b0;
      sel_idx_s   = ptr_r;
      for (int i = 0; i < NumReq; i++) begin
         if (!sel_found_s && req_i[wrap_add(ptr_r, i)]) begin
            sel_found_s = 1'b1;
            sel_idx_s   = wrap_add(ptr_r, i);
         end else begin
            sel_found_s = sel_found_s;
         end
      end
   end

   // Transaction FSM with registered grant/valid/step/busy outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= IDLE;
         ptr_r   <= {PtrW{1'b0}};
         g_r     <= {PtrW{1'b0}};
         count_r <= 32'd0;
         gnt_r   <= {NumReq{1'b0}};
         valid_r <= 1'b0;
         next_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (sel_found_s) begin
                  g_r     <= sel_idx_s;
                  state_r <= STEP;
                  next_r  <= 1'b1;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  next_r  <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
            STEP: begin
               next_r <= 1'b0;
               if (!req_i[g_r]) begin
                  // Requester left before delivery: the stepped value is dropped.
                  state_r <= IDLE;
                  ptr_r   <= wrap_add(g_r, 1);
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= DELIVER;
                  valid_r <= 1'b1;
                  gnt_r   <= onehot(g_r);
               end
            end
            DELIVER: begin
               if (ready_i[g_r]) begin
                  count_r <= count_r + 32'd1;
                  ptr_r   <= wrap_add(g_r, 1);
                  state_r <= IDLE;
                  valid_r <= 1'b0;
                  gnt_r   <= {NumReq{1'b0}};
                  busy_r  <= 1'b0;
               end else if (!req_i[g_r]) begin
                  ptr_r   <= wrap_add(g_r, 1);
                  state_r <= IDLE;
                  valid_r <= 1'b0;
                  gnt_r   <= {NumReq{1'b0}};
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= DELIVER;
               end
            end
            default: begin
               state_r <= IDLE;
               gnt_r   <= {NumReq{1'b0}};
               valid_r <= 1'b0;
               next_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // LFSR does not step while valid, so the gated pass-through stays stable.
   assign data_o      = valid_r ? lfsr_rand_i : {Width{1'b0}};
   assign gnt_o       = gnt_r;
   assign valid_o     = valid_r;
   assign lfsr_next_o = next_r;
   assign busy_o      = busy_r;
   assign count_o     = count_r;

endmodule

// File: tb/tb_lfsr_share_arb.sv
// Directed bench for lfsr_share_arb driving a 16-bit Galois LFSR model.
module tb_lfsr_share_arb;
   localparam int N = 4;
   localparam int W = 16;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [N-1:0] req_i;
   logic [N-1:0] ready_i;
   logic [N-1:0] gnt_o;
   logic         valid_o;
   logic [W-1:0] data_o;
   logic         lfsr_next_o;
   logic [W-1:0] lfsr_rand_i;
   logic         busy_o;
   logic [31:0]  count_o;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          steps = 0;
   logic [15:0] lfsr = 16'hACE1;
   logic [15:0] exp_lfsr = 16'hACE1;
   int          exp_count = 0;
   logic [15:0] last_data;

   lfsr_share_arb #(.NumReq(N), .Width(W)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_i),
      .ready_i     (ready_i),
      .gnt_o       (gnt_o),
      .valid_o     (valid_o),
      .data_o      (data_o),
      .lfsr_next_o (lfsr_next_o),
      .lfsr_rand_i (lfsr_rand_i),
      .busy_o      (busy_o),
      .count_o     (count_o)
   );

   always #5 clk_i = ~clk_i;
   assign lfsr_rand_i = lfsr;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   always @(posedge clk_i) begin
      if (lfsr_next_o) begin
         lfsr  <= lfsr_step(lfsr);
         steps <= steps + 1;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full transfer from IDLE with ready[g] high; ends back in IDLE.
   task automatic xfer(input logic [3:0] req, input logic [3:0] rdy, input int g, input string tag);
      logic [3:0] oh;
      oh      = 4'b0001 << g;
      req_i   = req;
      ready_i = rdy;
      tick();
      chk($sformatf("%s_step_next", tag), 32'(lfsr_next_o), 32'd1);
      chk($sformatf("%s_step_valid", tag), 32'(valid_o), 32'd0);
      exp_lfsr = lfsr_step(exp_lfsr);
      tick();
      chk($sformatf("%s_gnt", tag), 32'(gnt_o), 32'(oh));
      chk($sformatf("%s_valid", tag), 32'(valid_o), 32'd1);
      chk($sformatf("%s_data", tag), 32'(data_o), 32'(exp_lfsr));
      chk($sformatf("%s_dlv_next", tag), 32'(lfsr_next_o), 32'd0);
      last_data = data_o;
      tick();
      exp_count++;
      chk($sformatf("%s_idle_valid", tag), 32'(valid_o), 32'd0);
      chk($sformatf("%s_idle_busy", tag), 32'(busy_o), 32'd0);
      chk($sformatf("%s_count", tag), count_o, 32'(exp_count));
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      rst_i     = 1'b0;
      exp_count = 0;
   endtask

   initial begin
      logic [15:0] prev;
      logic [15:0] disc;
      logic [15:0] hold_data;
      int          n_same;
      int          data_bad;
      int          steps0;
      longint      sum;
      longint      mean;

      rst_i   = 1'b1;
      req_i   = 4'b0000;
      ready_i = 4'b0000;
      tick();
      tick();
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_data", 32'(data_o), 32'd0);
      chk("rst_next", 32'(lfsr_next_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_count", count_o, 32'd0);
      rst_i = 1'b0;

      // Single requester, 10000 back-to-back transfers.
      req_i    = 4'b0001;
      ready_i  = 4'b0001;
      prev     = 16'd0;
      n_same   = 0;
      data_bad = 0;
      sum      = 0;
      steps0   = steps;
      for (int k = 0; k < 10000; k++) begin
         tick();
         exp_lfsr = lfsr_step(exp_lfsr);
         tick();
         if (data_o !== exp_lfsr || valid_o !== 1'b1 || lfsr_next_o !== 1'b0 || gnt_o !== 4'b0001)
            data_bad++;
         if (k > 0 && data_o == prev) n_same++;
         prev = data_o;
         sum  = sum + longint'(data_o);
         tick();
      end
      req_i   = 4'b0000;
      ready_i = 4'b0000;
      mean    = sum / 10000;
      chk("single_count", count_o, 32'd10000);
      chk("single_steps", 32'(steps - steps0), 32'd10000);
      chk("single_data", 32'(data_bad), 32'd0);
      chk("single_consec_diff", 32'(n_same), 32'd0);
      chk("single_mean_lo", 32'(mean >= 64'd26214), 32'd1);
      chk("single_mean_hi", 32'(mean <= 64'd39321), 32'd1);

      // Full contention after reset: rotation 0,1,2,3,0,1,2,3.
      do_reset();
      chk("cont_count0", count_o, 32'd0);
      for (int k = 0; k < 8; k++) begin
         xfer(4'b1111, 4'b1111, k % 4, $sformatf("cont%0d", k));
      end

      // Pointer rotation: grant 2, then 1001 goes to 3 then 0.
      xfer(4'b0100, 4'b0100, 2, "rot_a");
      xfer(4'b1001, 4'b1001, 3, "rot_b");
      xfer(4'b1001, 4'b1001, 0, "rot_c");

      // Backpressure on requester 1 for 5 cycles.
      steps0  = steps;
      req_i   = 4'b0010;
      ready_i = 4'b0000;
      tick();
      exp_lfsr = lfsr_step(exp_lfsr);
      tick();
      chk("bp_data0", 32'(data_o), 32'(exp_lfsr));
      hold_data = data_o;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("bp_valid%0d", k), 32'(valid_o), 32'd1);
         chk($sformatf("bp_gnt%0d", k), 32'(gnt_o), 32'h2);
         chk($sformatf("bp_data%0d", k), 32'(data_o), 32'(hold_data));
         chk($sformatf("bp_next%0d", k), 32'(lfsr_next_o), 32'd0);
      end
      ready_i = 4'b0010;
      tick();
      exp_count++;
      chk("bp_count", count_o, 32'(exp_count));
      chk("bp_valid_end", 32'(valid_o), 32'd0);
      chk("bp_steps", 32'(steps - steps0), 32'd1);

      // Withdrawal during STEP.
      req_i   = 4'b0100;
      ready_i = 4'b0000;
      tick();
      chk("wds_next", 32'(lfsr_next_o), 32'd1);
      exp_lfsr = lfsr_step(exp_lfsr);
      disc     = exp_lfsr;
      req_i    = 4'b0000;
      tick();
      chk("wds_busy", 32'(busy_o), 32'd0);
      chk("wds_valid", 32'(valid_o), 32'd0);
      chk("wds_count", count_o, 32'(exp_count));
      xfer(4'b1100, 4'b1100, 3, "wds_next_gnt");
      chk("wds_fresh", 32'(last_data != disc), 32'd1);

      // Withdrawal during DELIVER.
      req_i   = 4'b0001;
      ready_i = 4'b0000;
      tick();
      exp_lfsr = lfsr_step(exp_lfsr);
      tick();
      chk("wdd_valid", 32'(valid_o), 32'd1);
      disc  = data_o;
      req_i = 4'b0000;
      tick();
      chk("wdd_busy", 32'(busy_o), 32'd0);
      chk("wdd_valid_end", 32'(valid_o), 32'd0);
      chk("wdd_count", count_o, 32'(exp_count));
      xfer(4'b0011, 4'b0011, 1, "wdd_next_gnt");
      chk("wdd_fresh", 32'(last_data != disc), 32'd1);

      // Reset while in DELIVER with ready high.
      req_i   = 4'b0100;
      ready_i = 4'b0000;
      tick();
      exp_lfsr = lfsr_step(exp_lfsr);
      tick();
      chk("rd_valid_pre", 32'(valid_o), 32'd1);
      rst_i   = 1'b1;
      ready_i = 4'b0100;
      tick();
      rst_i     = 1'b0;
      exp_count = 0;
      chk("rd_valid", 32'(valid_o), 32'd0);
      chk("rd_gnt", 32'(gnt_o), 32'd0);
      chk("rd_count", count_o, 32'd0);
      chk("rd_busy", 32'(busy_o), 32'd0);
      xfer(4'b1111, 4'b1111, 0, "rd_next_gnt");
      req_i   = 4'b0000;
      ready_i = 4'b0000;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
